// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Control bundle layout (MSB..LSB):
// {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst[1:0], Branch, ALUOp[3:0]}.
// An all-zero bundle is a NOP: no register write, no memory access, no branch.
package id_ex_reg_pkg;

  localparam int unsigned IdExDw     = 32;
  localparam int unsigned IdExAw     = 5;
  localparam int unsigned IdExCtrlW  = 12;
  localparam int unsigned IdExShamtW = 5;

  // What the register does on a given clock edge.
  typedef enum logic [1:0] {
    OpLoad  = 2'd0,
    OpHold  = 2'd1,
    OpFlush = 2'd2
  } pipe_op_e;

  // Flush beats stall, stall beats a normal load.
  function automatic pipe_op_e pipe_op(input logic flush, input logic stall);
    pipe_op_e op;
    if (flush) begin
      op = OpFlush;
    end else if (stall) begin
      op = OpHold;
    end else begin
      op = OpLoad;
    end
    return op;
  endfunction

endpackage

// File: rtl/id_ex_bypass.sv
// Same-cycle WB->ID bypass for one register-file read port.
// Register 0 is hard-wired to zero, so a WB write to it is never forwarded.
module id_ex_bypass
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW = IdExDw,
  parameter int unsigned AW = IdExAw
) (
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] rf_data,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] data
);

  // Select WB data when the write in flight targets the register being read.
  always_comb begin
    data = rf_data;
    if (wb_we && (wb_addr != '0) && (wb_addr == idx)) begin
      data = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold (stall), bubble insertion (flush / invalid ID)
// and a WB->ID bypass on the operand fields.
// Optional: define ID_EX_PERF_CNT_EN to add the perf_bubbles / perf_stalls counters.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DW    = IdExDw,
  parameter int unsigned AW    = IdExAw,
  parameter int unsigned CTRLW = IdExCtrlW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DW-1:0]         id_pc4,
  input  logic [DW-1:0]         id_rs_data,
  input  logic [DW-1:0]         id_rt_data,
  input  logic [DW-1:0]         id_imm_ext,
  input  logic [AW-1:0]         id_rs,
  input  logic [AW-1:0]         id_rt,
  input  logic [AW-1:0]         id_rd,
  input  logic [IdExShamtW-1:0] id_shamt,
  input  logic [CTRLW-1:0]      id_ctrl,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DW-1:0]         wb_data,
  output logic                  ex_valid,
  output logic [DW-1:0]         ex_pc4,
  output logic [DW-1:0]         ex_rs_data,
  output logic [DW-1:0]         ex_rt_data,
  output logic [DW-1:0]         ex_imm_ext,
  output logic [AW-1:0]         ex_rs,
  output logic [AW-1:0]         ex_rt,
  output logic [AW-1:0]         ex_rd,
  output logic [IdExShamtW-1:0] ex_shamt,
  output logic [CTRLW-1:0]      ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           perf_bubbles,
  output logic [31:0]           perf_stalls
`endif
);

  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  pipe_op_e      op;

  id_ex_bypass #(
    .DW(DW),
    .AW(AW)
  ) u_bypass_rs (
    .idx    (id_rs),
    .rf_data(id_rs_data),
    .wb_we  (wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .data   (rs_fwd)
  );

  id_ex_bypass #(
    .DW(DW),
    .AW(AW)
  ) u_bypass_rt (
    .idx    (id_rt),
    .rf_data(id_rt_data),
    .wb_we  (wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .data   (rt_fwd)
  );

  assign op = pipe_op(flush, stall);

  // Pipeline register update: flush > stall > load; counters track bubbles and stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm_ext <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_shamt   <= '0;
      ex_ctrl    <= '0;
`ifdef ID_EX_PERF_CNT_EN
      perf_bubbles <= '0;
      perf_stalls  <= '0;
`endif
    end else begin
      case (op)
        OpFlush: begin
          ex_valid   <= 1'b0;
          ex_pc4     <= '0;
          ex_rs_data <= '0;
          ex_rt_data <= '0;
          ex_imm_ext <= '0;
          ex_rs      <= '0;
          ex_rt      <= '0;
          ex_rd      <= '0;
          ex_shamt   <= '0;
          ex_ctrl    <= '0;
`ifdef ID_EX_PERF_CNT_EN
          perf_bubbles <= perf_bubbles + 32'd1;
`endif
        end
        OpHold: begin
          // Everything holds; a WB write during the stall is picked up by forwarding in EX.
`ifdef ID_EX_PERF_CNT_EN
          perf_stalls <= perf_stalls + 32'd1;
`endif
        end
        default: begin
          ex_valid   <= id_valid;
          ex_pc4     <= id_pc4;
          ex_rs_data <= rs_fwd;
          ex_rt_data <= rt_fwd;
          ex_imm_ext <= id_imm_ext;
          ex_rs      <= id_rs;
          ex_rt      <= id_rt;
          ex_rd      <= id_rd;
          ex_shamt   <= id_shamt;
          // Mask control so EX can use ex_ctrl without qualifying by ex_valid.
          ex_ctrl    <= id_valid ? id_ctrl : '0;
`ifdef ID_EX_PERF_CNT_EN
          if (!id_valid) begin
            perf_bubbles <= perf_bubbles + 32'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule
